pulse_stretcher: RTL and testbench

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

---
 rtl/pulse_stretcher.sv | 141 ++++++++++++++
 tb/tb_pulse_stretcher.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle trig events into stretched pulse_out
// levels of programmable width, separated by a programmable low gap.
// Events arriving while a pulse or gap is in progress are queued in a
// saturating 4-bit counter and replayed back to back; events that find the
// queue full are dropped and flagged in a sticky overflow bit.
module pulse_stretcher (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [7:0] width,
    input  logic [7:0] gap,
    input  logic       clr_ovf,
    output logic       pulse_out,
    output logic       busy,
    output logic [3:0] pending,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [3:0] PEND_MAX = 4'd15;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] pend_q, pend_d;
    logic       ovf_q, ovf_d;
    logic       pulse_q, pulse_d;
    logic       busy_q, busy_d;

    logic [7:0] widthEff;
    logic [7:0] gapEff;
    logic       enq;
    logic       deq;
    logic       drop;

    // Next-state logic: phase sequencing, queue bookkeeping and overflow flag.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        enq      = 1'b0;
        deq      = 1'b0;
        widthEff = (width == 8'd0) ? 8'd1 : width;
        gapEff   = (gap == 8'd0) ? 8'd1 : gap;

        case (state_q)
            IDLE: begin
                // The queue is always empty here, so a trig starts a pulse directly.
                if (trig) begin
                    state_d = HIGH;
                    cnt_d   = widthEff;
                end
            end
            HIGH: begin
                enq = trig;
                if (cnt_q <= 8'd1) begin
                    state_d = GAP;
                    cnt_d   = gapEff;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            GAP: begin
                if (cnt_q <= 8'd1) begin
                    if (pend_q != 4'd0) begin
                        // Replay a queued event; a trig in this cycle joins the queue.
                        state_d = HIGH;
                        cnt_d   = widthEff;
                        deq     = 1'b1;
                        enq     = trig;
                    end else if (trig) begin
                        // Nothing queued: this trig is served by the pulse starting now.
                        state_d = HIGH;
                        cnt_d   = widthEff;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = 8'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    enq   = trig;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        // A dequeue in the same cycle frees a slot, so a full queue only drops
        // when nothing is leaving it.
        drop = enq && !deq && (pend_q == PEND_MAX);

        pend_d = pend_q;
        if (enq && !deq && (pend_q != PEND_MAX)) begin
            pend_d = pend_q + 4'd1;
        end else if (deq && !enq) begin
            pend_d = pend_q - 4'd1;
        end

        // A drop in the same cycle as a clear must leave the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        pulse_d = (state_d == HIGH);
        busy_d  = (state_d != IDLE);
    end

    // State register with synchronous reset; reset overrides trig and clr_ovf.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            pend_q  <= 4'd0;
            ovf_q   <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign pending   = pend_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: scenario-driven bench for pulse_stretcher. Each step
// pushes the expected output tuple, advances one clock edge, then pops the
// tuple and compares it against the outputs settled after that edge.
module tb_pulse_stretcher;

    logic       clk;
    logic       rst;
    logic       trig;
    logic [7:0] width;
    logic [7:0] gap;
    logic       clr_ovf;
    logic       pulse_out;
    logic       busy;
    logic [3:0] pending;
    logic       overflow;

    typedef struct packed {
        logic       p;
        logic       b;
        logic [3:0] pend;
        logic       ovf;
    } exp_t;

    exp_t sbQ[$];
    int   checks = 0;
    int   errors = 0;

    pulse_stretcher dut (
        .clk       (clk),
        .rst       (rst),
        .trig      (trig),
        .width     (width),
        .gap       (gap),
        .clr_ovf   (clr_ovf),
        .pulse_out (pulse_out),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic string fmtTuple(input exp_t v);
        return $sformatf("p=%b busy=%b pend=%0d ovf=%b", v.p, v.b, v.pend, v.ovf);
    endfunction

    function automatic exp_t mkExp(input int p, input int b, input int pend, input int ovf);
        exp_t v;
        v.p    = (p != 0);
        v.b    = (b != 0);
        v.pend = 4'(pend);
        v.ovf  = (ovf != 0);
        return v;
    endfunction

    // Drives one set of inputs, then returns 1 time unit after the next rising edge.
    task automatic applyStimulus(input logic r, input logic t, input logic c);
        rst     = r;
        trig    = t;
        clr_ovf = c;
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        exp_t e;
        exp_t got;
        for (int i = 0; i < 3; i++) begin
            sbQ.push_back(mkExp(0, 0, 0, 0));
            // trig and clr_ovf are asserted alongside rst and must be ignored.
            applyStimulus(i < 2, i < 2, i < 2);
            e   = sbQ.pop_front();
            got = {pulse_out, busy, pending, overflow};
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL reset step %0d: got %s, want %s", i, fmtTuple(got), fmtTuple(e));
            end
        end
    endtask

    task automatic test_single_event();
        int   trigSeq[7] = '{1, 0, 0, 0, 0, 0, 0};
        int   pSeq[7]    = '{1, 1, 1, 0, 0, 0, 0};
        int   bSeq[7]    = '{1, 1, 1, 1, 1, 0, 0};
        exp_t e;
        exp_t got;
        width = 8'd3;
        gap   = 8'd2;
        resetDut();
        for (int i = 0; i < 7; i++) begin
            sbQ.push_back(mkExp(pSeq[i], bSeq[i], 0, 0));
            applyStimulus(1'b0, trigSeq[i] != 0, 1'b0);
            e   = sbQ.pop_front();
            got = {pulse_out, busy, pending, overflow};
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL single_event step %0d: got %s, want %s", i, fmtTuple(got), fmtTuple(e));
            end
        end
    endtask

    task automatic test_queueing();
        int   trigSeq[10] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        int   pSeq[10]    = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 0};
        int   bSeq[10]    = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        int   pendSeq[10] = '{0, 1, 2, 1, 1, 1, 0, 0, 0, 0};
        exp_t e;
        exp_t got;
        width = 8'd2;
        gap   = 8'd1;
        resetDut();
        for (int i = 0; i < 10; i++) begin
            sbQ.push_back(mkExp(pSeq[i], bSeq[i], pendSeq[i], 0));
            applyStimulus(1'b0, trigSeq[i] != 0, 1'b0);
            e   = sbQ.pop_front();
            got = {pulse_out, busy, pending, overflow};
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL queueing step %0d: got %s, want %s", i, fmtTuple(got), fmtTuple(e));
            end
        end
    endtask

    task automatic test_zero_params();
        int   trigSeq[9] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
        int   pSeq[9]    = '{1, 0, 1, 0, 1, 0, 1, 0, 0};
        int   bSeq[9]    = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
        int   pendSeq[9] = '{0, 1, 1, 2, 1, 1, 0, 0, 0};
        exp_t e;
        exp_t got;
        width = 8'd0;
        gap   = 8'd0;
        resetDut();
        for (int i = 0; i < 9; i++) begin
            sbQ.push_back(mkExp(pSeq[i], bSeq[i], pendSeq[i], 0));
            applyStimulus(1'b0, trigSeq[i] != 0, 1'b0);
            e   = sbQ.pop_front();
            got = {pulse_out, busy, pending, overflow};
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL zero_params step %0d: got %s, want %s", i, fmtTuple(got), fmtTuple(e));
            end
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        exp_t got;
        int   pulses;
        int   highCycles;
        int   cyc;
        logic prevPulse;
        width = 8'd255;
        gap   = 8'd1;
        resetDut();
        // Steps 0..19 hold trig; step 17 also raises clr_ovf during a drop.
        // Step 20 releases trig and clears the flag.
        for (int i = 0; i < 21; i++) begin
            sbQ.push_back(mkExp(1, 1, (i < 15) ? i : 15, (i >= 16) && (i < 20)));
            applyStimulus(1'b0, i < 20, (i == 17) || (i == 20));
            e   = sbQ.pop_front();
            got = {pulse_out, busy, pending, overflow};
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL overflow step %0d: got %s, want %s", i, fmtTuple(got), fmtTuple(e));
            end
        end
        // Let the queue drain, counting pulses and high cycles.
        pulses     = 1;
        highCycles = 21;
        prevPulse  = pulse_out;
        cyc        = 0;
        while (busy === 1'b1 && cyc < 6000) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            if (pulse_out === 1'b1 && prevPulse !== 1'b1) pulses++;
            if (pulse_out === 1'b1) highCycles++;
            prevPulse = pulse_out;
            cyc++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overflow_drain_timeout: busy=%b after %0d cycles, want 0", busy, cyc);
        end
        checks++;
        if (pulses != 16) begin
            errors++;
            $display("[TB] FAIL overflow_pulse_count: got %0d, want 16", pulses);
        end
        checks++;
        if (highCycles != 16 * 255) begin
            errors++;
            $display("[TB] FAIL overflow_high_cycles: got %0d, want %0d", highCycles, 16 * 255);
        end
        checks++;
        if (pending !== 4'd0 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overflow_final: got pend=%0d ovf=%b, want pend=0 ovf=0", pending, overflow);
        end
    endtask

    task automatic test_reset_mid_pulse();
        exp_t e;
        exp_t got;
        width = 8'd10;
        gap   = 8'd1;
        resetDut();
        // Steps 0..2 trig, step 3 is rst together with trig, then idle.
        for (int i = 0; i < 19; i++) begin
            if (i < 3) sbQ.push_back(mkExp(1, 1, i, 0));
            else       sbQ.push_back(mkExp(0, 0, 0, 0));
            applyStimulus(i == 3, i <= 3, 1'b0);
            e   = sbQ.pop_front();
            got = {pulse_out, busy, pending, overflow};
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL reset_mid_pulse step %0d: got %s, want %s", i, fmtTuple(got), fmtTuple(e));
            end
        end
    endtask

    task automatic test_last_gap_trig();
        int   trigSeq[9] = '{1, 0, 0, 0, 0, 1, 0, 0, 0};
        int   pSeq[9]    = '{1, 1, 0, 0, 0, 1, 0, 0, 0};
        int   bSeq[9]    = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
        exp_t e;
        exp_t got;
        width = 8'd2;
        gap   = 8'd3;
        resetDut();
        for (int i = 0; i < 9; i++) begin
            sbQ.push_back(mkExp(pSeq[i], bSeq[i], 0, 0));
            applyStimulus(1'b0, trigSeq[i] != 0, 1'b0);
            // Mid-pulse and mid-gap changes apply only to the next pulse and gap.
            if (i == 0) width = 8'd1;
            if (i == 2) gap = 8'd1;
            e   = sbQ.pop_front();
            got = {pulse_out, busy, pending, overflow};
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL last_gap_trig step %0d: got %s, want %s", i, fmtTuple(got), fmtTuple(e));
            end
        end
    endtask

    // Scenario sequence.
    initial begin
        rst     = 1'b1;
        trig    = 1'b0;
        clr_ovf = 1'b0;
        width   = 8'd1;
        gap     = 8'd1;
        @(posedge clk);
        #1;
        test_reset();
        test_single_event();
        test_queueing();
        test_zero_params();
        test_overflow();
        test_reset_mid_pulse();
        test_last_gap_trig();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
